// File: rtl/sd_pattern_gen.sv
// rtl/sd_pattern_gen.sv - srdy/drdy burst traffic source with optional idle gaps and abort
//
// Purpose: on an accepted start, presents num_words words on p_data under the
//          srdy/drdy hold-until-accepted rule. The words count up from seed.
//          A 16-bit gap LFSR can insert single idle cycles between words.
//          abort ends the burst early, but never withdraws a word that is
//          already presented.
// Ports:   clk, reset (sync, active-low)
//          start, abort, num_words, seed, gap_en  - burst control
//          p_srdy, p_drdy, p_data                 - output stream
//          busy, done, sent_count                 - status
// Optional: define SD_PATGEN_LFSR_DATA_EN to take data words from a
//          seed-loaded 16-bit LFSR instead of an incrementing counter.
module sd_pattern_gen #(
    parameter int width     = 16,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [cnt_width-1:0] num_words,
    input  logic [width-1:0]     seed,
    input  logic                 gap_en,
    output logic                 p_srdy,
    input  logic                 p_drdy,
    output logic [width-1:0]     p_data,
    output logic                 busy,
    output logic                 done,
    output logic [cnt_width-1:0] sent_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_srdy;
    logic [width-1:0]       r_data;
    logic [cnt_width-1:0]   r_sent;
    logic [cnt_width-1:0]   r_num;
    logic [15:0]            r_gap_lfsr;
    logic                   r_abort_pend;

    logic                   w_xfer;
    logic                   w_last;
    logic                   w_gap;
    logic                   w_start_go;
    logic                   w_busy;
    logic                   w_done;
    logic [width-1:0]       w_load_data;
    logic [width-1:0]       w_step_data;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit 15 is tap 16)
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign w_xfer     = r_srdy & p_drdy;
    assign w_last     = (r_sent + cnt_width'(1)) == r_num;
    // gap decision uses the LFSR value from before this transfer's advance
    assign w_gap      = gap_en & (r_gap_lfsr[1:0] == 2'b00);
    assign w_start_go = (r_state == S_IDLE) & start & (num_words != '0);

`ifdef SD_PATGEN_LFSR_DATA_EN
    logic [15:0] r_data_lfsr;
    logic [15:0] w_seed16;
    logic [15:0] w_seed_lfsr;
    logic [15:0] w_data_lfsr_nxt;

    for (genvar gi = 0; gi < 16; gi++) begin : g_seed
        if (gi < width) begin : g_bit
            assign w_seed16[gi] = seed[gi];
        end else begin : g_zero
            assign w_seed16[gi] = 1'b0;
        end
    end

    // an all-zero LFSR would lock up, so a zero seed starts at 1
    assign w_seed_lfsr     = (w_seed16 == 16'h0000) ? 16'h0001 : w_seed16;
    assign w_data_lfsr_nxt = lfsr_step(r_data_lfsr);

    for (genvar gi = 0; gi < width; gi++) begin : g_data
        if (gi < 16) begin : g_bit
            assign w_load_data[gi] = w_seed_lfsr[gi];
            assign w_step_data[gi] = w_data_lfsr_nxt[gi];
        end else begin : g_zero
            assign w_load_data[gi] = 1'b0;
            assign w_step_data[gi] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_lfsr <= 16'h0001;
        end else if (w_start_go) begin
            r_data_lfsr <= w_seed_lfsr;
        end else if (w_xfer) begin
            r_data_lfsr <= w_data_lfsr_nxt;
        end
    end
`else
    assign w_load_data = seed;
    assign w_step_data = r_data + width'(1);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_words != '0) ? S_SEND : S_DONE;
                end
            end
            S_SEND: begin
                w_busy = 1'b1;
                if (r_srdy) begin
                    if (w_xfer && (w_last || r_abort_pend || abort)) begin
                        w_state_nxt = S_DONE;
                    end
                end else if (abort) begin
                    // gap cycle: nothing is presented, so stop at once
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_srdy       <= 1'b0;
            r_data       <= '0;
            r_sent       <= '0;
            r_num        <= '0;
            r_gap_lfsr   <= 16'hACE1;
            r_abort_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sent <= '0;
                        if (num_words != '0) begin
                            r_num  <= num_words;
                            r_data <= w_load_data;
                            r_srdy <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (r_srdy) begin
                        if (w_xfer) begin
                            r_sent     <= r_sent + cnt_width'(1);
                            r_data     <= w_step_data;
                            r_gap_lfsr <= lfsr_step(r_gap_lfsr);
                            if (w_last || r_abort_pend || abort || w_gap) begin
                                r_srdy <= 1'b0;
                            end
                        end else if (abort) begin
                            // the presented word must stay until accepted
                            r_abort_pend <= 1'b1;
                        end
                    end else if (!abort) begin
                        r_srdy <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_abort_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign p_srdy     = r_srdy;
    assign p_data     = r_data;
    assign busy       = w_busy;
    assign done       = w_done;
    assign sent_count = r_sent;
endmodule

// File: tb/tb_sd_pattern_gen.sv
// tb/tb_sd_pattern_gen.sv - randomized self-checking bench for sd_pattern_gen
module tb_sd_pattern_gen;
    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] num_words;
    logic [W-1:0]  seed;
    logic          gap_en;
    logic          p_srdy;
    logic          p_drdy;
    logic [W-1:0]  p_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] sent_count;

    always #5 clk = ~clk;

    sd_pattern_gen #(.width(W), .cnt_width(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_words  (num_words),
        .seed       (seed),
        .gap_en     (gap_en),
        .p_srdy     (p_srdy),
        .p_drdy     (p_drdy),
        .p_data     (p_data),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // reference model: burst contents as a queue of words still to be sent
    bit          m_active;
    bit          m_done;
    bit          m_srdy;
    bit          m_pend;
    logic [15:0] m_sent;
    logic [15:0] m_lfsr;
    logic [15:0] m_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
        return {s[14:0], fb};
    endfunction

    task automatic model_edge();
        bit gap_now;
        logic [15:0] w;
        if (!reset) begin
            m_active = 0; m_done = 0; m_srdy = 0; m_pend = 0;
            m_sent = 16'h0; m_lfsr = 16'hACE1;
            m_q.delete();
            return;
        end
        if (m_done) begin
            m_done = 0; m_pend = 0;
            return;
        end
        if (!m_active) begin
            if (start) begin
                m_sent = 16'h0;
                if (num_words == 0) begin
                    m_done = 1;
                end else begin
                    m_q.delete();
`ifdef SD_PATGEN_LFSR_DATA_EN
                    w = (seed == 0) ? 16'h0001 : seed;
                    for (int k = 0; k < int'(num_words); k++) begin
                        m_q.push_back(w);
                        w = lfsr_next(w);
                    end
`else
                    w = seed;
                    for (int k = 0; k < int'(num_words); k++) m_q.push_back(w + 16'(k));
`endif
                    m_active = 1; m_srdy = 1;
                end
            end
            return;
        end
        if (m_srdy) begin
            if (p_drdy) begin
                void'(m_q.pop_front());
                m_sent++;
                gap_now = gap_en && (m_lfsr[1:0] == 2'b00);
                m_lfsr  = lfsr_next(m_lfsr);
                if (m_q.size() == 0 || m_pend || abort) begin
                    m_active = 0; m_done = 1; m_srdy = 0;
                end else if (gap_now) begin
                    m_srdy = 0;
                end
            end else if (abort) begin
                m_pend = 1;
            end
        end else if (abort) begin
            m_active = 0; m_done = 1;
        end else begin
            m_srdy = 1;
        end
    endtask

    // one clock: inputs are already set; model advances at the edge, outputs compared at negedge
    task automatic step();
        logic pre_srdy, pre_xfer, pre_rst;
        logic [W-1:0] pre_data;
        pre_srdy = p_srdy;
        pre_data = p_data;
        pre_xfer = p_srdy & p_drdy;
        pre_rst  = reset;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("srdy", p_srdy, m_srdy);
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("sent_count", sent_count, m_sent);
        if (m_srdy && m_q.size() > 0) check("data", p_data, m_q[0]);
        if (pre_rst === 1'b1 && reset === 1'b1 && pre_srdy === 1'b1 && pre_xfer === 1'b0) begin
            check("hold_srdy", p_srdy, 1'b1);
            check("hold_data", p_data, pre_data);
        end
    endtask

    task automatic launch(input logic [15:0] nw, input logic [15:0] sd);
        start = 1; num_words = nw; seed = sd;
        step();
        start = 0;
    endtask

    int ndone;

    initial begin
        reset = 0; start = 0; abort = 0; num_words = 0; seed = 0; gap_en = 0; p_drdy = 0;
        step(); step();
        check("reset_data", p_data, 16'h0000);
        reset = 1;
        step();

        // plain burst across a carry
        p_drdy = 1;
        launch(16'd4, 16'h00FE);
        for (int i = 0; i < 6; i++) step();
        check("burst4_sent", sent_count, 16'd4);

        // stall on the second word
        launch(16'd4, 16'h00FE);
        p_drdy = 1; step();
        p_drdy = 0; step(); step(); step();
        p_drdy = 1;
        for (int i = 0; i < 6; i++) step();
        check("stall_sent", sent_count, 16'd4);

        // data wrap
        launch(16'd2, 16'hFFFF);
        for (int i = 0; i < 4; i++) step();
        check("wrap_sent", sent_count, 16'd2);

        // zero-length burst
        launch(16'd0, 16'h1234);
        check("zero_done", done, 1'b1);
        step(); step();
        check("zero_sent", sent_count, 16'd0);

        // abort with the fourth word presented and stalled
        gap_en = 1;
        launch(16'd10, 16'h0100);
        for (int i = 0; i < 60 && !(sent_count == 16'd3 && p_srdy); i++) step();
        check("abort_reach3", {sent_count, 15'd0, p_srdy}, {16'd3, 15'd0, 1'b1});
        p_drdy = 0; abort = 1; step();
        abort = 0; step(); step();
        p_drdy = 1;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) ndone++;
        end
        check("abort_sent", sent_count, 16'd4);
        check("abort_done_pulses", ndone, 1);

        // reset mid-burst
        gap_en = 0;
        launch(16'd10, 16'h0200);
        step(); step();
        reset = 0; step();
        check("midrst_srdy", p_srdy, 1'b0);
        check("midrst_done", done, 1'b0);
        reset = 1;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 299) != 0);
            start  = ($urandom_range(0, 5) == 0);
            abort  = ($urandom_range(0, 24) == 0);
            gap_en = 1'($urandom_range(0, 1));
            p_drdy = ($urandom_range(0, 3) != 0);
            num_words = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            seed = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
